// File: rtl/preif_pcgen_pkg.sv
// Shared CPU defines for the pre-IF PC generator: exception vector type,
// redirect priority levels, PC generator states and priority encoder helper.
package preif_pcgen_pkg;

    typedef struct packed {
        logic Interrupt;
        logic WrongAddressinIF;
        logic TLBRefillinIF;
        logic TLBInvalidinIF;
        logic ReservedInstruction;
        logic Syscall;
        logic Break;
        logic Eret;
        logic WrongAddressinMEM;
        logic TLBRefillinMEM;
        logic TLBInvalidinMEM;
        logic TLBModified;
        logic Overflow;
        logic RefetchFlush;
    } ExceptinPipeType;

    // Numeric order is the arbitration order: larger value wins.
    typedef enum logic [1:0] {
        PRIO_NONE    = 2'd0,
        PRIO_EXE     = 2'd1,
        PRIO_REFETCH = 2'd2,
        PRIO_EXC     = 2'd3
    } redirect_prio_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } pcgen_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic redirect_prio_e redirect_prio(input logic exc, input logic refetch,
                                                     input logic exe);
        redirect_prio_e p;
        if (exc) begin
            p = PRIO_EXC;
        end else if (refetch) begin
            p = PRIO_REFETCH;
        end else if (exe) begin
            p = PRIO_EXE;
        end else begin
            p = PRIO_NONE;
        end
        return p;
    endfunction

endpackage

// File: rtl/preif_redirect_latch.sv
// Holds a redirect target while the I-cache has not yet accepted the stale
// request; only a strictly higher-priority redirect may replace it.
module preif_redirect_latch
    import preif_pcgen_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           upd,
    input  logic           clr,
    input  redirect_prio_e in_prio,
    input  logic [31:0]    in_target,
    output logic [31:0]    eff_target
);

    redirect_prio_e prio_r;
    logic [31:0]    target_r;
    logic           higher_s;

    assign higher_s = (in_prio > prio_r);

    // Target seen by the PC register when leaving PEND, including a same-cycle stronger arrival
    always_comb begin
        if (higher_s) begin
            eff_target = in_target;
        end else begin
            eff_target = target_r;
        end
    end

    // Latch storage with strict-priority overwrite
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_r   <= PRIO_NONE;
            target_r <= 32'h0000_0000;
        end else if (clr) begin
            prio_r   <= PRIO_NONE;
            target_r <= 32'h0000_0000;
        end else if (upd && higher_s) begin
            prio_r   <= in_prio;
            target_r <= in_target;
        end else begin
            prio_r   <= prio_r;
            target_r <= target_r;
        end
    end

endmodule

// File: rtl/preif_pcgen.sv
// Pre-IF PC generator with redirect arbitration and stale-request kill.
// Branch-prediction targets are used only when PREIF_BPU_EN is defined.
module preif_pcgen
    import preif_pcgen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            PREIF_Wr,
    input  logic            IF_BPUValid,
    input  logic [31:0]     IF_Target,
    input  logic            EXE_Redirect,
    input  logic [31:0]     EXE_RedirectPC,
    input  logic            MEM_Refetch,
    input  logic [31:0]     MEM_RefetchPC,
    input  logic            MEM_ExcValid,
    input  logic [31:0]     MEM_ExcPC,
    output logic            ibus_req,
    output logic [31:0]     ibus_addr,
    input  logic            ibus_addr_ok,
    output logic [31:0]     PREIF_PC,
    output ExceptinPipeType PREIF_ExceptType,
    output logic            PREIF_Valid,
    output logic            PREIF_Kill
);

    pcgen_state_e   state_r;
    logic [31:0]    pc_r;
    logic           valid_r;
    logic           req_s;
    logic           fire_s;
    logic           leave_s;
    logic           redirect_s;
    logic           latch_upd_s;
    logic           latch_clr_s;
    logic [31:0]    redir_target_s;
    logic [31:0]    latch_target_s;
    logic [31:0]    seq_pc_s;
    redirect_prio_e redir_prio_s;

    assign req_s        = valid_r && PREIF_Wr && (pc_r[1:0] == 2'b00);
    assign fire_s       = req_s && ibus_addr_ok;
    assign leave_s      = fire_s || !req_s;
    assign redir_prio_s = redirect_prio(MEM_ExcValid, MEM_Refetch, EXE_Redirect);
    assign redirect_s   = (redir_prio_s != PRIO_NONE);

    // Target of the winning redirect source
    always_comb begin
        case (redir_prio_s)
            PRIO_EXC:     redir_target_s = MEM_ExcPC;
            PRIO_REFETCH: redir_target_s = MEM_RefetchPC;
            PRIO_EXE:     redir_target_s = EXE_RedirectPC;
            default:      redir_target_s = pc_r;
        endcase
    end

`ifdef PREIF_BPU_EN
    // Sequential path: predicted-taken target or fall-through
    always_comb begin
        if (IF_BPUValid) begin
            seq_pc_s = IF_Target;
        end else begin
            seq_pc_s = pc_r + PC_STEP;
        end
    end
`else
    logic bpu_unused_s;
    assign bpu_unused_s = IF_BPUValid ^ (^IF_Target);

    // Sequential path is always fall-through without a predictor
    always_comb begin
        seq_pc_s = pc_r + PC_STEP;
    end
`endif

    // A stalled request cannot be retracted, so the redirect waits in the latch
    assign latch_upd_s = !leave_s && ((state_r == ST_PEND) || redirect_s);
    assign latch_clr_s = (state_r == ST_PEND) && leave_s;

    preif_redirect_latch u_latch (
        .clk        (clk),
        .resetn     (resetn),
        .upd        (latch_upd_s),
        .clr        (latch_clr_s),
        .in_prio    (redir_prio_s),
        .in_target  (redir_target_s),
        .eff_target (latch_target_s)
    );

    // PC / state / valid register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_RUN;
            pc_r    <= RESET_PC;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b1;
            case (state_r)
                ST_RUN: begin
                    if (redirect_s && leave_s) begin
                        pc_r    <= redir_target_s;
                        state_r <= ST_RUN;
                    end else if (redirect_s) begin
                        pc_r    <= pc_r;
                        state_r <= ST_PEND;
                    end else if (fire_s) begin
                        pc_r    <= seq_pc_s;
                        state_r <= ST_RUN;
                    end else begin
                        pc_r    <= pc_r;
                        state_r <= ST_RUN;
                    end
                end
                ST_PEND: begin
                    if (leave_s) begin
                        pc_r    <= latch_target_s;
                        state_r <= ST_RUN;
                    end else begin
                        pc_r    <= pc_r;
                        state_r <= ST_PEND;
                    end
                end
                default: begin
                    pc_r    <= pc_r;
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    // Alignment exception flag for the current PC
    always_comb begin
        PREIF_ExceptType = ExceptinPipeType'({$bits(ExceptinPipeType){1'b0}});
        PREIF_ExceptType.WrongAddressinIF = (pc_r[1:0] != 2'b00);
    end

    assign ibus_req    = req_s;
    assign ibus_addr   = pc_r;
    assign PREIF_PC    = pc_r;
    assign PREIF_Valid = valid_r;
    assign PREIF_Kill  = (state_r == ST_PEND) && fire_s;

endmodule

// File: tb/tb_preif_pcgen.sv
// Directed bench for preif_pcgen: cycle-level reference model plus pinned
// hand-computed fetch addresses; honours PREIF_BPU_EN the same way as the DUT.
module tb_preif_pcgen
    import preif_pcgen_pkg::*;
;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic            clk = 1'b0;
    logic            resetn;
    logic            PREIF_Wr;
    logic            IF_BPUValid;
    logic [31:0]     IF_Target;
    logic            EXE_Redirect;
    logic [31:0]     EXE_RedirectPC;
    logic            MEM_Refetch;
    logic [31:0]     MEM_RefetchPC;
    logic            MEM_ExcValid;
    logic [31:0]     MEM_ExcPC;
    logic            ibus_req;
    logic [31:0]     ibus_addr;
    logic            ibus_addr_ok;
    logic [31:0]     PREIF_PC;
    ExceptinPipeType PREIF_ExceptType;
    logic            PREIF_Valid;
    logic            PREIF_Kill;

    int checks = 0;
    int errors = 0;

    logic        pin_on;
    string       pin_name;
    logic [31:0] pin_addr;
    logic        pin_req;
    logic        pin_kill;

    preif_pcgen #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .PREIF_Wr         (PREIF_Wr),
        .IF_BPUValid      (IF_BPUValid),
        .IF_Target        (IF_Target),
        .EXE_Redirect     (EXE_Redirect),
        .EXE_RedirectPC   (EXE_RedirectPC),
        .MEM_Refetch      (MEM_Refetch),
        .MEM_RefetchPC    (MEM_RefetchPC),
        .MEM_ExcValid     (MEM_ExcValid),
        .MEM_ExcPC        (MEM_ExcPC),
        .ibus_req         (ibus_req),
        .ibus_addr        (ibus_addr),
        .ibus_addr_ok     (ibus_addr_ok),
        .PREIF_PC         (PREIF_PC),
        .PREIF_ExceptType (PREIF_ExceptType),
        .PREIF_Valid      (PREIF_Valid),
        .PREIF_Kill       (PREIF_Kill)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_pending;
    logic [31:0] m_ptgt;
    int          m_plvl;

    always @(negedge clk) begin
        logic            e_req;
        logic            e_fire;
        logic            e_kill;
        logic            use_bpu;
        int              lvl;
        logic [31:0]     tgt;
        ExceptinPipeType e_exc;

        if (!resetn) begin
            m_pc      = RST_PC;
            m_valid   = 1'b0;
            m_pending = 1'b0;
            m_ptgt    = 32'h0;
            m_plvl    = 0;
        end

        e_req  = m_valid && PREIF_Wr && ((m_pc % 32'd4) == 32'd0);
        e_fire = e_req && ibus_addr_ok;
        e_kill = m_pending && e_fire;
        e_exc  = ExceptinPipeType'({$bits(ExceptinPipeType){1'b0}});
        e_exc.WrongAddressinIF = ((m_pc % 32'd4) != 32'd0);

        check("ibus_req", {31'd0, ibus_req}, {31'd0, e_req});
        check("ibus_addr", ibus_addr, m_pc);
        check("PREIF_PC", PREIF_PC, m_pc);
        check("PREIF_Valid", {31'd0, PREIF_Valid}, {31'd0, m_valid});
        check("PREIF_Kill", {31'd0, PREIF_Kill}, {31'd0, e_kill});
        check("ExceptType", 32'(PREIF_ExceptType), 32'(e_exc));

        if (pin_on) begin
            check({pin_name, "_addr"}, ibus_addr, pin_addr);
            check({pin_name, "_req"}, {31'd0, ibus_req}, {31'd0, pin_req});
            check({pin_name, "_kill"}, {31'd0, PREIF_Kill}, {31'd0, pin_kill});
            check({pin_name, "_model"}, m_pc, pin_addr);
        end

        if (resetn) begin
            if (MEM_ExcValid) begin
                lvl = 3; tgt = MEM_ExcPC;
            end else if (MEM_Refetch) begin
                lvl = 2; tgt = MEM_RefetchPC;
            end else if (EXE_Redirect) begin
                lvl = 1; tgt = EXE_RedirectPC;
            end else begin
                lvl = 0; tgt = m_pc;
            end
`ifdef PREIF_BPU_EN
            use_bpu = IF_BPUValid;
`else
            use_bpu = 1'b0;
`endif
            if (!m_pending) begin
                if (lvl > 0) begin
                    if (!e_req || e_fire) begin
                        m_pc = tgt;
                    end else begin
                        m_pending = 1'b1;
                        m_ptgt    = tgt;
                        m_plvl    = lvl;
                    end
                end else if (e_fire) begin
                    m_pc = use_bpu ? IF_Target : m_pc + 32'd4;
                end
            end else begin
                if (lvl > m_plvl) begin
                    m_ptgt = tgt;
                    m_plvl = lvl;
                end
                if (e_fire || !e_req) begin
                    m_pc      = m_ptgt;
                    m_pending = 1'b0;
                end
            end
            m_valid = 1'b1;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        EXE_Redirect = 1'b0;
        MEM_Refetch  = 1'b0;
        MEM_ExcValid = 1'b0;
        IF_BPUValid  = 1'b0;
        pin_on       = 1'b0;
    endtask

    task automatic pin(input string name, input logic [31:0] addr, input logic req,
                       input logic kill);
        pin_name = name;
        pin_addr = addr;
        pin_req  = req;
        pin_kill = kill;
        pin_on   = 1'b1;
    endtask

    logic [31:0] bpu_exp;

    initial begin
        resetn = 1'b0; PREIF_Wr = 1'b1; ibus_addr_ok = 1'b1;
        IF_BPUValid = 1'b0; IF_Target = 32'h0;
        EXE_Redirect = 1'b0; EXE_RedirectPC = 32'h0;
        MEM_Refetch = 1'b0; MEM_RefetchPC = 32'h0;
        MEM_ExcValid = 1'b0; MEM_ExcPC = 32'h0;
        pin_on = 1'b0; pin_name = ""; pin_addr = 32'h0; pin_req = 1'b0; pin_kill = 1'b0;
        pin("in_reset", 32'hBFC0_0000, 1'b0, 1'b0);

        nxt(); pin("in_reset2", 32'hBFC0_0000, 1'b0, 1'b0);
        nxt(); resetn = 1'b1; pin("rst_release", 32'hBFC0_0000, 1'b0, 1'b0);
        nxt(); pin("seq0", 32'hBFC0_0000, 1'b1, 1'b0);
        nxt(); pin("seq1", 32'hBFC0_0004, 1'b1, 1'b0);
        nxt(); pin("seq2", 32'hBFC0_0008, 1'b1, 1'b0);

        // Redirect while the I-cache stalls for three cycles
        nxt(); ibus_addr_ok = 1'b0; EXE_Redirect = 1'b1; EXE_RedirectPC = 32'h8000_1000;
        pin("stall0", 32'hBFC0_000C, 1'b1, 1'b0);
        nxt(); pin("stall1", 32'hBFC0_000C, 1'b1, 1'b0);
        nxt(); pin("stall2", 32'hBFC0_000C, 1'b1, 1'b0);
        nxt(); ibus_addr_ok = 1'b1; pin("kill", 32'hBFC0_000C, 1'b1, 1'b1);
        nxt(); pin("redir", 32'h8000_1000, 1'b1, 1'b0);

        // Exception beats branch redirect; lower-priority redirect in PEND ignored
        nxt(); ibus_addr_ok = 1'b0;
        EXE_Redirect = 1'b1; EXE_RedirectPC = 32'h8000_3000;
        MEM_ExcValid = 1'b1; MEM_ExcPC = 32'hBFC0_0380;
        pin("prio_stall", 32'h8000_1004, 1'b1, 1'b0);
        nxt(); EXE_Redirect = 1'b1; EXE_RedirectPC = 32'h8000_4000;
        pin("pend_low", 32'h8000_1004, 1'b1, 1'b0);
        nxt(); ibus_addr_ok = 1'b1; pin("kill2", 32'h8000_1004, 1'b1, 1'b1);
        nxt(); pin("exc_vec", 32'hBFC0_0380, 1'b1, 1'b0);

        // Redirect coinciding with fire; refetch beats branch
        nxt(); EXE_Redirect = 1'b1; EXE_RedirectPC = 32'h8000_5000;
        pin("redir_fire", 32'hBFC0_0384, 1'b1, 1'b0);
        nxt(); MEM_Refetch = 1'b1; MEM_RefetchPC = 32'h8000_6000;
        EXE_Redirect = 1'b1; EXE_RedirectPC = 32'h8000_7000;
        pin("exe_tgt", 32'h8000_5000, 1'b1, 1'b0);
        nxt(); pin("refetch_tgt", 32'h8000_6000, 1'b1, 1'b0);

        // Higher-priority overwrite in PEND, then request drops without kill
        nxt(); ibus_addr_ok = 1'b0; EXE_Redirect = 1'b1; EXE_RedirectPC = 32'h8000_8000;
        pin("pend_exe", 32'h8000_6004, 1'b1, 1'b0);
        nxt(); MEM_Refetch = 1'b1; MEM_RefetchPC = 32'h8000_9000;
        pin("pend_ovw", 32'h8000_6004, 1'b1, 1'b0);
        nxt(); PREIF_Wr = 1'b0; pin("req_drop", 32'h8000_6004, 1'b0, 1'b0);
        nxt(); PREIF_Wr = 1'b1; ibus_addr_ok = 1'b1;
        pin("ovw_tgt", 32'h8000_9000, 1'b1, 1'b0);

        // Branch prediction on fire
        nxt(); IF_BPUValid = 1'b1; IF_Target = 32'h8000_2000;
        pin("bpu_fire", 32'h8000_9004, 1'b1, 1'b0);
`ifdef PREIF_BPU_EN
        bpu_exp = 32'h8000_2000;
`else
        bpu_exp = 32'h8000_9008;
`endif
        nxt(); pin("bpu_next", bpu_exp, 1'b1, 1'b0);

        // Address wrap and stall hold
        nxt(); MEM_ExcValid = 1'b1; MEM_ExcPC = 32'hFFFF_FFFC;
        nxt(); pin("wrap_pre", 32'hFFFF_FFFC, 1'b1, 1'b0);
        nxt(); pin("wrap", 32'h0000_0000, 1'b1, 1'b0);
        nxt(); PREIF_Wr = 1'b0; pin("wr_hold", 32'h0000_0004, 1'b0, 1'b0);
        nxt(); PREIF_Wr = 1'b1; pin("wr_resume", 32'h0000_0004, 1'b1, 1'b0);

        // Misaligned refetch target, then exception recovery
        nxt(); MEM_Refetch = 1'b1; MEM_RefetchPC = 32'h8000_0002;
        pin("pre_mis", 32'h0000_0008, 1'b1, 1'b0);
        nxt(); pin("misalign", 32'h8000_0002, 1'b0, 1'b0);
        nxt(); pin("mis_hold", 32'h8000_0002, 1'b0, 1'b0);
        nxt(); MEM_ExcValid = 1'b1; MEM_ExcPC = 32'hBFC0_0380;
        pin("mis_exc", 32'h8000_0002, 1'b0, 1'b0);
        nxt(); pin("recover", 32'hBFC0_0380, 1'b1, 1'b0);

        // Reset in the middle of PEND discards the latched target
        nxt(); ibus_addr_ok = 1'b0; EXE_Redirect = 1'b1; EXE_RedirectPC = 32'h8000_B000;
        pin("pend_b", 32'hBFC0_0384, 1'b1, 1'b0);
        nxt(); resetn = 1'b0; pin("rst_pend", 32'hBFC0_0000, 1'b0, 1'b0);
        nxt(); ibus_addr_ok = 1'b1; pin("rst_hold", 32'hBFC0_0000, 1'b0, 1'b0);
        nxt(); resetn = 1'b1; pin("rst_rel2", 32'hBFC0_0000, 1'b0, 1'b0);
        nxt(); pin("rst_fetch", 32'hBFC0_0000, 1'b1, 1'b0);
        nxt(); pin("rst_fetch1", 32'hBFC0_0004, 1'b1, 1'b0);
        nxt();

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/preif_pcgen.md
PREIF_PCGEN -- requirements
Module: preif_pcgen

Interface
- REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, the first fetch address after reset.
- REQ-002 SHALL have port clk, input, 1, sole clock; all state rising-edge.
- REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
- REQ-004 SHALL have port PREIF_Wr, input, 1, IF stage able to accept a new PC (0 = stall).
- REQ-005 SHALL have ports IF_BPUValid (input, 1) and IF_Target (input, 32): predicted-taken target from BPU.
- REQ-006 SHALL have ports EXE_Redirect (input, 1) and EXE_RedirectPC (input, 32): branch mispredict correction.
- REQ-007 SHALL have ports MEM_Refetch (input, 1) and MEM_RefetchPC (input, 32): refetch after CP0/TLB write.
- REQ-008 SHALL have ports MEM_ExcValid (input, 1) and MEM_ExcPC (input, 32): exception/eret vector.
- REQ-009 SHALL have ports ibus_req (output, 1), ibus_addr (output, 32) and ibus_addr_ok (input, 1): I-cache address handshake.
- REQ-010 SHALL have ports PREIF_PC (output, 32), PREIF_ExceptType (output, ExceptinPipeType), PREIF_Valid (output, 1) and PREIF_Kill (output, 1, the request accepted this cycle is stale and IF SHALL drop it).

Function
- REQ-011 SHALL define fire = ibus_req && ibus_addr_ok.
- REQ-012 SHALL drive ibus_addr = PREIF_PC and ibus_req = PREIF_Valid && PREIF_Wr && (PREIF_PC[1:0] == 2'b00).
- REQ-013 SHALL keep ibus_addr stable while ibus_req=1 and ibus_addr_ok=0.
- REQ-014 SHALL select the next PC with priority MEM_ExcValid > MEM_Refetch > EXE_Redirect > IF_BPUValid > PREIF_PC+4 (mod 2^32, wraps silently).
- REQ-015 SHALL have states RUN and PEND.
- REQ-016 In RUN, with no redirect: SHALL load the next PC on fire, otherwise hold.
- REQ-017 In RUN, with a redirect (MEM_ExcValid, MEM_Refetch or EXE_Redirect) and (!ibus_req || fire): SHALL load the redirect target next cycle regardless of PREIF_Wr.
- REQ-018 In RUN, with a redirect while ibus_req && !ibus_addr_ok: SHALL latch the target and its priority and enter PEND.
- REQ-019 In PEND: SHALL leave PREIF_PC unchanged until fire or until ibus_req drops.
- REQ-020 In PEND, on fire: SHALL assert PREIF_Kill that cycle, load the latched target and return to RUN.
- REQ-021 In PEND, if ibus_req drops: SHALL load the latched target and return to RUN without asserting PREIF_Kill.
- REQ-022 In PEND: a redirect of strictly higher priority SHALL overwrite the latch; equal or lower priority redirects and IF_BPUValid SHALL be ignored.
- REQ-023 IF_BPUValid SHALL be honoured only in RUN, on fire.
- REQ-024 SHALL set PREIF_ExceptType.WrongAddressinIF = (PREIF_PC[1:0] != 0) with all other fields 0.
- REQ-025 With PREIF_PC misaligned: ibus_req SHALL stay 0 and PC SHALL hold until a redirect arrives.
- REQ-026 PREIF_Valid SHALL be 0 in reset and rise on the first clk edge after resetn deasserts.

Reset
- REQ-027 On resetn=0: PREIF_PC=RESET_PC, state=RUN, PREIF_Valid=0, PREIF_Kill=0, ibus_req=0, latch cleared, immediately and independent of clk.
- REQ-028 Reset asserted mid-PEND SHALL discard the latched target.

Configuration
- REQ-029 With macro PREIF_BPU_EN defined: IF_BPUValid/IF_Target SHALL participate per REQ-014 and REQ-023.
- REQ-030 With PREIF_BPU_EN undefined: IF_BPUValid SHALL be ignored and the sequential path SHALL always be PC+4.

Structure
- REQ-031 ExceptinPipeType and the redirect-priority enum SHALL reside in the shared CPU defines package; RESET_PC SHALL stay a module parameter.
- REQ-032 The PEND latch (target, priority, overwrite rule) SHALL be sub-module preif_redirect_latch.

Verification
- REQ-033 Release reset, ibus_addr_ok=1 constant -> ibus_addr sequence BFC00000, BFC00004, BFC00008.
- REQ-034 EXE_Redirect to 0x80001000 while ibus_addr_ok=0 for 3 cycles -> addr held, then PREIF_Kill=1 on accept, next addr 0x80001000.
- REQ-035 EXE_Redirect and MEM_ExcValid (0xBFC00380) in the same cycle -> next addr 0xBFC00380; a later EXE_Redirect in PEND -> ignored.
- REQ-036 PREIF_BPU_EN defined, IF_BPUValid=1, IF_Target=0x80002000 on fire -> next addr 0x80002000; undefined -> PC+4.
- REQ-037 MEM_Refetch to 0x80000002 -> WrongAddressinIF=1, ibus_req=0; a following MEM_ExcValid -> recovers to the vector.
- REQ-038 PREIF_PC=0xFFFFFFFC with fire -> next 0x00000000; resetn low during PEND -> PC=RESET_PC, PREIF_Kill never asserted.
